// File: rtl/pc_redirect_ctrl.sv
// OTTER program-counter sequencer: PC register, fetch handshake, next-PC select,
// misalignment trap, redirect flush and taken-redirect counter. Optional PC_INTR_EN adds interrupt entry.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             fetch_req,
    input  logic             fetch_ack,
    input  logic             exec_valid,
    input  logic [2:0]       op_class,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic [31:0]      jal_target,
    input  logic [31:0]      jalr_target,
    input  logic [31:0]      mtvec,
    input  logic [31:0]      mepc,
    output logic [31:0]      PC,
    output logic             redirect,
    output logic             flush,
    output logic             misalign_trap,
    output logic [CNT_W-1:0] redir_cnt
`ifdef PC_INTR_EN
    ,
    input  logic             intr,
    output logic             intr_taken,
    output logic [31:0]      epc_out
`endif
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JAL    = 3'd2;
    localparam logic [2:0] OP_JALR   = 3'd3;
    localparam logic [2:0] OP_MRET   = 3'd4;
    localparam logic [2:0] OP_ECALL  = 3'd5;

    // FLUSH is left when the down-counter reaches zero, so it is loaded with N-1.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0]       state_reg, state_next;
    logic [31:0]      pc_reg;
    logic [2:0]       flush_cnt_reg;
    logic             redirect_reg;
    logic             misalign_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [31:0] pc_plus4;
    logic [31:0] npc_raw;
    logic [31:0] npc;
    logic [31:0] pc_final;
    logic        is_jump;
    logic        misaligned;
    logic        retire;
    logic        take_redirect;

    // Bit 0 of the JALR target is architecturally discarded.
    logic unused_jalr_lsb;
    assign unused_jalr_lsb = jalr_target[0];

    assign pc_plus4 = pc_reg + 32'd4;
    assign retire   = (state_reg == ST_EXEC) && exec_valid;

    always_comb begin
        npc_raw = pc_plus4;
        is_jump = 1'b0;
        case (op_class)
            OP_BRANCH: begin
                if (br_taken) begin
                    npc_raw = br_target;
                    is_jump = 1'b1;
                end
            end
            OP_JAL: begin
                npc_raw = jal_target;
                is_jump = 1'b1;
            end
            OP_JALR: begin
                npc_raw = {jalr_target[31:1], 1'b0};
                is_jump = 1'b1;
            end
            OP_MRET: begin
                npc_raw = mepc;
                is_jump = 1'b1;
            end
            OP_ECALL: begin
                npc_raw = mtvec;
                is_jump = 1'b1;
            end
            default: begin
                npc_raw = pc_plus4;
                is_jump = 1'b0;
            end
        endcase
    end

    assign misaligned = (npc_raw[1:0] != 2'b00);
    assign npc        = misaligned ? mtvec : npc_raw;

`ifdef PC_INTR_EN
    logic        intr_pend_reg;
    logic        intr_fire;
    logic        intr_taken_reg;
    logic [31:0] epc_reg;

    // A misalignment trap wins; the interrupt stays pending for the next retirement.
    assign intr_fire = retire && !misaligned && (intr || intr_pend_reg);
    assign pc_final  = intr_fire ? mtvec : npc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            intr_pend_reg  <= 1'b0;
            intr_taken_reg <= 1'b0;
            epc_reg        <= 32'h0;
        end else begin
            intr_taken_reg <= intr_fire;
            if (intr_fire) begin
                intr_pend_reg <= 1'b0;
                epc_reg       <= npc;
            end else if (intr) begin
                intr_pend_reg <= 1'b1;
            end
        end
    end

    assign intr_taken = intr_taken_reg;
    assign epc_out    = epc_reg;
`else
    localparam logic intr_fire = 1'b0;
    assign pc_final = npc;
`endif

    assign take_redirect = is_jump || misaligned || intr_fire;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: if (fetch_ack) state_next = ST_EXEC;
            ST_EXEC: begin
                if (exec_valid) state_next = take_redirect ? ST_FLUSH : ST_FETCH;
            end
            ST_FLUSH: if (flush_cnt_reg == 3'd0) state_next = ST_FETCH;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= RESET_VEC;
            flush_cnt_reg <= 3'd0;
            redirect_reg  <= 1'b0;
            misalign_reg  <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            redirect_reg <= retire && take_redirect;
            misalign_reg <= retire && misaligned;
            if (retire) begin
                pc_reg <= pc_final;
                if (take_redirect) begin
                    flush_cnt_reg <= FLUSH_LOAD;
                    if (~&cnt_reg) cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else if (state_reg == ST_FLUSH && flush_cnt_reg != 3'd0) begin
                flush_cnt_reg <= flush_cnt_reg - 3'd1;
            end
        end
    end

    assign fetch_req     = (state_reg == ST_FETCH);
    assign flush         = (state_reg == ST_FLUSH);
    assign PC            = pc_reg;
    assign redirect      = redirect_reg;
    assign misalign_trap = misalign_reg;
    assign redir_cnt     = cnt_reg;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Table-driven bench for pc_redirect_ctrl (FLUSH_CYCLES=2, 3-bit counter to reach saturation).
module tb_pc_redirect_ctrl;

    localparam int CNT_W = 3;
    localparam logic [31:0] MTVEC = 32'h0000_0080;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             fetch_req;
    logic             fetch_ack = 1'b0;
    logic             exec_valid = 1'b0;
    logic [2:0]       op_class = 3'd0;
    logic             br_taken = 1'b0;
    logic [31:0]      br_target = 32'h0;
    logic [31:0]      jal_target = 32'h0;
    logic [31:0]      jalr_target = 32'h0;
    logic [31:0]      mtvec = MTVEC;
    logic [31:0]      mepc = 32'h0;
    logic [31:0]      PC;
    logic             redirect;
    logic             flush;
    logic             misalign_trap;
    logic [CNT_W-1:0] redir_cnt;
`ifdef PC_INTR_EN
    logic             intr = 1'b0;
    logic             intr_taken;
    logic [31:0]      epc_out;
`endif

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl #(
        .RESET_VEC   (32'h0000_0000),
        .FLUSH_CYCLES(2),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .fetch_req    (fetch_req),
        .fetch_ack    (fetch_ack),
        .exec_valid   (exec_valid),
        .op_class     (op_class),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jal_target   (jal_target),
        .jalr_target  (jalr_target),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .PC           (PC),
        .redirect     (redirect),
        .flush        (flush),
        .misalign_trap(misalign_trap),
        .redir_cnt    (redir_cnt)
`ifdef PC_INTR_EN
        ,
        .intr         (intr),
        .intr_taken   (intr_taken),
        .epc_out      (epc_out)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]       op;
        logic             taken;
        logic [31:0]      tgt;
        int               ack_dly;
        logic [31:0]      exp_pc;
        logic             exp_redir;
        logic             exp_mis;
        int               exp_flush;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_intr;
        logic [31:0]      exp_epc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH through retirement and any flush.
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        chk("fetch_req_in_fetch", {31'd0, fetch_req}, 32'd1);
        for (int i = 0; i < v.ack_dly; i++) @(posedge CLK);
        #1 fetch_ack = 1'b1;
        @(posedge CLK);
        #1 fetch_ack = 1'b0;
        chk("fetch_req_in_exec", {31'd0, fetch_req}, 32'd0);
        br_target   = 32'hBAD0_0010;
        jal_target  = 32'hBAD0_0020;
        jalr_target = 32'hBAD0_0030;
        mepc        = 32'hBAD0_0040;
        case (v.op)
            3'd1: br_target = v.tgt;
            3'd2: jal_target = v.tgt;
            3'd3: jalr_target = v.tgt;
            3'd4: mepc = v.tgt;
            default: ;
        endcase
        op_class   = v.op;
        br_taken   = v.taken;
        exec_valid = 1'b1;
        @(posedge CLK);
        #1 exec_valid = 1'b0;
        $display("vec %0d op=%0d tgt=%h -> PC=%h redirect=%b misalign=%b cnt=%0d",
                 idx, v.op, v.tgt, PC, redirect, misalign_trap, redir_cnt);
        chk("pc", PC, v.exp_pc);
        chk("redirect", {31'd0, redirect}, {31'd0, v.exp_redir});
        chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, v.exp_mis});
`ifdef PC_INTR_EN
        chk("intr_taken", {31'd0, intr_taken}, {31'd0, v.exp_intr});
        if (v.exp_intr) chk("epc_out", epc_out, v.exp_epc);
`endif
        n = 0;
        while (flush && n < 16) begin
            n++;
            @(posedge CLK);
            #1;
            if (n == 1) chk("redirect_one_cycle", {31'd0, redirect}, 32'd0);
        end
        chk("flush_cycles", n, v.exp_flush);
        chk("redir_cnt", {29'd0, redir_cnt}, {29'd0, v.exp_cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //         op    tk    tgt            ack exp_pc         rd    mis   fl cnt   intr  epc
        vecs[0]  = '{3'd0, 1'b0, 32'h0,         0, 32'h0000_0004, 1'b0, 1'b0, 0, 3'd0, 1'b0, 32'h0};
        vecs[1]  = '{3'd0, 1'b0, 32'h0,         1, 32'h0000_0008, 1'b0, 1'b0, 0, 3'd0, 1'b0, 32'h0};
        vecs[2]  = '{3'd0, 1'b0, 32'h0,         2, 32'h0000_000C, 1'b0, 1'b0, 0, 3'd0, 1'b0, 32'h0};
        vecs[3]  = '{3'd1, 1'b1, 32'h100,       0, 32'h0000_0100, 1'b1, 1'b0, 2, 3'd1, 1'b0, 32'h0};
        vecs[4]  = '{3'd1, 1'b0, 32'h500,       1, 32'h0000_0104, 1'b0, 1'b0, 0, 3'd1, 1'b0, 32'h0};
        vecs[5]  = '{3'd2, 1'b0, 32'h300,       0, 32'h0000_0300, 1'b1, 1'b0, 2, 3'd2, 1'b0, 32'h0};
        vecs[6]  = '{3'd3, 1'b0, 32'h203,       3, MTVEC,         1'b1, 1'b1, 2, 3'd3, 1'b0, 32'h0};
        vecs[7]  = '{3'd4, 1'b0, 32'h84,        0, 32'h0000_0084, 1'b1, 1'b0, 2, 3'd4, 1'b0, 32'h0};
        vecs[8]  = '{3'd5, 1'b0, 32'h0,         1, MTVEC,         1'b1, 1'b0, 2, 3'd5, 1'b0, 32'h0};
        vecs[9]  = '{3'd6, 1'b1, 32'h0,         0, 32'h0000_0084, 1'b0, 1'b0, 0, 3'd5, 1'b0, 32'h0};
        vecs[10] = '{3'd7, 1'b1, 32'h0,         0, 32'h0000_0088, 1'b0, 1'b0, 0, 3'd5, 1'b0, 32'h0};
        vecs[11] = '{3'd2, 1'b0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1'b1, 1'b0, 2, 3'd6, 1'b0, 32'h0};
        vecs[12] = '{3'd0, 1'b0, 32'h0,         2, 32'h0000_0000, 1'b0, 1'b0, 0, 3'd6, 1'b0, 32'h0};
        vecs[13] = '{3'd1, 1'b1, 32'h102,       0, MTVEC,         1'b1, 1'b1, 2, 3'd7, 1'b0, 32'h0};
        vecs[14] = '{3'd2, 1'b0, 32'h10,        0, 32'h0000_0010, 1'b1, 1'b0, 2, 3'd7, 1'b0, 32'h0};
        vecs[15] = '{3'd3, 1'b0, 32'h201,       1, 32'h0000_0200, 1'b1, 1'b0, 2, 3'd7, 1'b0, 32'h0};

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        $display("reset: PC=%h fetch_req=%b flush=%b cnt=%0d", PC, fetch_req, flush, redir_cnt);
        chk("reset_pc", PC, 32'h0);
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_misalign", {31'd0, misalign_trap}, 32'd0);
        chk("reset_cnt", {29'd0, redir_cnt}, 32'd0);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // exec_valid outside EXEC must not retire anything.
        op_class = 3'd2; jal_target = 32'h700; exec_valid = 1'b1;
        repeat (2) @(posedge CLK);
        #1 exec_valid = 1'b0;
        $display("ignored exec_valid in FETCH: PC=%h fetch_req=%b redirect=%b", PC, fetch_req, redirect);
        chk("ignore_exec_pc", PC, 32'h200);
        chk("ignore_exec_fetch_req", {31'd0, fetch_req}, 32'd1);
        chk("ignore_exec_redirect", {31'd0, redirect}, 32'd0);

        // Reset in the middle of a flush.
        fetch_ack = 1'b1;
        @(posedge CLK);
        #1 fetch_ack = 1'b0;
        op_class = 3'd1; br_taken = 1'b1; br_target = 32'h100; exec_valid = 1'b1;
        @(posedge CLK);
        #1 exec_valid = 1'b0;
        chk("pre_reset_flush", {31'd0, flush}, 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        $display("reset mid-flush: PC=%h flush=%b redirect=%b cnt=%0d", PC, flush, redirect, redir_cnt);
        chk("rst_flush_pc", PC, 32'h0);
        chk("rst_flush_flush", {31'd0, flush}, 32'd0);
        chk("rst_flush_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_flush_cnt", {29'd0, redir_cnt}, 32'd0);
        chk("rst_flush_fetch_req", {31'd0, fetch_req}, 32'd1);

`ifdef PC_INTR_EN
        run_vec(100, '{3'd2, 1'b0, 32'h40, 0, 32'h40, 1'b1, 1'b0, 2, 3'd1, 1'b0, 32'h0});
        intr = 1'b1;
        @(posedge CLK);
        #1 intr = 1'b0;
        run_vec(101, '{3'd0, 1'b0, 32'h0, 1, MTVEC, 1'b1, 1'b0, 2, 3'd2, 1'b1, 32'h44});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
